// File: rtl/uart_wb_bridge.sv
// Wishbone classic slave giving the bus a register view of UartTop:
// TX FIFO feeding the UART transmit handshake, RX holding register,
// status/control registers and a level interrupt.
module uart_wb_bridge #(
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq,
  output logic [7:0]  uart_w_data,
  output logic        uart_valid,
  input  logic        uart_busy,
  input  logic [7:0]  uart_word,
  input  logic        uart_rxne,
  output logic        uart_rxne_clear
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TX_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CLR, R_DROP} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [7:0]       mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [8:0]       cnt_ext;

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ovr, tx_ovf, rx_ie, tx_ie;
  logic        tx_full, tx_empty;
  logic        req, wr_tx, rd_rx, wr_ctrl, clr_flags, flush;
  logic        push, pop, capture, ovf_set, ovr_set;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^wb_dat_i[31:8];

  assign tx_full  = (count == FULL_CNT);
  assign tx_empty = (count == '0);
  assign cnt_ext  = 9'(count);

  // A transfer is taken on the cycle before ack; its side effects land with ack.
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_tx     = req &  wb_we_i & (wb_adr_i == 2'd0);
  assign rd_rx     = req & ~wb_we_i & (wb_adr_i == 2'd1);
  assign wr_ctrl   = req &  wb_we_i & (wb_adr_i == 2'd3);
  assign clr_flags = wr_ctrl & wb_dat_i[0];
  assign flush     = wr_ctrl & wb_dat_i[1];

  assign push    = wr_tx & ~tx_full;
  assign ovf_set = wr_tx &  tx_full;
  assign capture = (rx_state == R_IDLE) & uart_rxne;
  // A read landing in the capture cycle consumes the old byte, so no overrun.
  assign ovr_set = capture & rx_valid & ~rd_rx;

  assign uart_valid      = (tx_state == SEND);
  assign uart_rxne_clear = (rx_state == R_CLR);

  // Read-data mux for the addressed register.
  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      2'd1: rdata[7:0]  = rx_byte;
      2'd2: rdata[15:0] = {cnt_ext[7:0], 2'b00, tx_ovf, uart_busy,
                           rx_ovr, rx_valid, tx_empty, tx_full};
      2'd3: rdata[3:0]  = {tx_ie, rx_ie, 2'b00};
      default: rdata = '0;
    endcase
  end

  // Bus acknowledge and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
    end
  end

  // TX FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_dat_i[7:0];
  end

  // TX FIFO pointers and occupancy; flush wins over same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // TX FSM next state: hand the head byte over, wait for busy, wait for idle.
  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    unique case (tx_state)
      IDLE: if (!tx_empty && !uart_busy) begin
        pop     = 1'b1;
        tx_next = SEND;
      end
      SEND:    if (uart_busy)  tx_next = WAIT;
      WAIT:    if (!uart_busy) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  // TX FSM state and the byte presented to the UART.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= IDLE;
      uart_w_data <= '0;
    end else begin
      tx_state <= tx_next;
      if (pop) uart_w_data <= mem[rd_ptr];
    end
  end

  // RX FSM next state: capture, hold clear until RXNE drops, one quiet cycle.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      R_IDLE:  if (uart_rxne)  rx_next = R_CLR;
      R_CLR:   if (!uart_rxne) rx_next = R_DROP;
      R_DROP:  rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // RX FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // RX holding register, status flags and control bits; a set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_ie    <= 1'b0;
      tx_ie    <= 1'b0;
    end else begin
      if (capture) rx_byte <= uart_word;
      if (capture)    rx_valid <= 1'b1;
      else if (rd_rx) rx_valid <= 1'b0;
      if (ovr_set)        rx_ovr <= 1'b1;
      else if (clr_flags) rx_ovr <= 1'b0;
      if (ovf_set)        tx_ovf <= 1'b1;
      else if (clr_flags) tx_ovf <= 1'b0;
      if (wr_ctrl) begin
        rx_ie <= wb_dat_i[2];
        tx_ie <= wb_dat_i[3];
      end
    end
  end

  // Registered interrupt line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (rx_ie & rx_valid) | (tx_ie & tx_empty & ~uart_busy);
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Testbench for uart_wb_bridge: register vectors, UART TX/RX models,
// TX byte scoreboard and hand-written corner sequences.
module tb_uart_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, irq;
  logic [7:0]  uart_w_data;
  logic        uart_valid, uart_busy;
  logic [7:0]  uart_word;
  logic        uart_rxne, uart_rxne_clear;

  uart_wb_bridge #(.TX_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .irq(irq),
    .uart_w_data(uart_w_data), .uart_valid(uart_valid), .uart_busy(uart_busy),
    .uart_word(uart_word), .uart_rxne(uart_rxne), .uart_rxne_clear(uart_rxne_clear)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // TX scoreboard and model controls
  logic [7:0] tx_exp[$];
  int tx_mode = 0;   // 0 normal UART, 1 busy forced high, 2 stalled (busy low, never accepts)
  int tx_cnt  = 0;
  int tx_vio  = 0;
  int bit_cnt = 0;

  // RX model controls
  int         rx_req_cnt  = 0;
  int         rx_done_cnt = 0;
  logic [7:0] rx_req_word = 8'h00;
  logic       rx_hold     = 1'b0;

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
    logic        rd;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                         output logic [31:0] rd);
    int n;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) begin
      n_total++;
      $display("FAIL wb_ack_timeout: no ack after %0d cycles, adr %0d", n, adr);
    end
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wb_xfer(1'b1, adr, dat, rd);
  endtask

  task automatic wb_read(input logic [1:0] adr, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'h0, rd);
    chk(nm, rd, exp);
  endtask

  task automatic tx_write(input logic [7:0] b, input logic accepted);
    wb_write(2'd0, {24'h0, b});
    if (accepted) tx_exp.push_back(b);
  endtask

  task automatic wait_tx_idle(input int bound);
    int n = 0;
    while ((tx_exp.size() != 0 || uart_busy || uart_valid) && n < bound) begin
      @(posedge clk); n++;
    end
    if (n >= bound) begin
      n_total++;
      $display("FAIL tx_drain_timeout: %0d bytes pending after %0d cycles", tx_exp.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_req_word = b;
    rx_req_cnt++;
    @(negedge clk);
    @(posedge clk); #1;
    chk("rxne_clear_rise", {31'h0, uart_rxne_clear}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("rxne_clear_fall", {31'h0, uart_rxne_clear}, 32'h0);
  endtask

  // UART transmit side: accept on valid, stay busy a few cycles, score each byte.
  initial begin
    logic [7:0] e;
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_valid && uart_busy) tx_vio++;
      case (tx_mode)
        1: uart_busy = 1'b1;
        2: uart_busy = 1'b0;
        default: begin
          if (uart_busy) begin
            if (bit_cnt == 0) uart_busy = 1'b0;
            else bit_cnt--;
          end else if (uart_valid) begin
            tx_cnt++;
            if (tx_exp.size() == 0) begin
              n_total++;
              $display("FAIL tx_unexpected: got 0x%02h, expected no byte", uart_w_data);
            end else begin
              e = tx_exp.pop_front();
              chk("tx_byte", {24'h0, uart_w_data}, {24'h0, e});
            end
            uart_busy = 1'b1;
            bit_cnt = 5;
          end
        end
      endcase
    end
  end

  // UART receive side: raise RXNE on request, drop it once clear is seen.
  initial begin
    uart_rxne = 1'b0;
    uart_word = 8'h00;
    forever begin
      @(negedge clk);
      if (uart_rxne && uart_rxne_clear) begin
        if (!rx_hold) uart_rxne = 1'b0;
      end else if (!uart_rxne && !uart_rxne_clear && rx_req_cnt != rx_done_cnt) begin
        uart_word = rx_req_word;
        uart_rxne = 1'b1;
        rx_done_cnt++;
      end
    end
  end

  initial begin
    logic [31:0] rd;
    vecs[0] = '{1'b0, 2'd2, 32'h0,  32'h0000_0002, 1'b1};
    vecs[1] = '{1'b0, 2'd1, 32'h0,  32'h0000_0000, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 32'h0,  32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 2'd3, 32'h0,  32'h0000_0000, 1'b1};
    vecs[4] = '{1'b1, 2'd3, 32'hC,  32'h0,         1'b0};
    vecs[5] = '{1'b0, 2'd3, 32'h0,  32'h0000_000C, 1'b1};
    vecs[6] = '{1'b1, 2'd3, 32'h3,  32'h0,         1'b0};
    vecs[7] = '{1'b0, 2'd3, 32'h0,  32'h0000_0000, 1'b1};
    vecs[8] = '{1'b1, 2'd2, 32'hFF, 32'h0,         1'b0};

    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 2'd0; wb_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {wb_dat_o[15:0], uart_w_data, 4'h0, wb_ack_o, irq, uart_valid, uart_rxne_clear},
        32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state and single-cycle ack
    wb_read(2'd2, 32'h2, "status_after_reset");
    @(posedge clk); #1;
    chk("ack_single_cycle", {31'h0, wb_ack_o}, 32'h0);
    chk("irq_after_reset", {31'h0, irq}, 32'h0);

    // register vectors
    for (int i = 0; i < 9; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd);
      if (vecs[i].rd) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    wb_read(2'd2, 32'h2, "status_write_ignored");

    // three bytes through a live UART
    tx_write(8'h41, 1'b1);
    tx_write(8'h42, 1'b1);
    tx_write(8'h43, 1'b1);
    wait_tx_idle(500);
    chk("tx_count_abc", tx_cnt, 3);
    wb_read(2'd2, 32'h2, "status_after_abc");

    // overflow with the UART held busy
    tx_mode = 1;
    for (int i = 0; i < 17; i++) tx_write(8'h60 + 8'(i), i < 16);
    wb_read(2'd2, 32'h0000_1031, "status_full_ovf");
    wb_write(2'd3, 32'h1);
    wb_read(2'd2, 32'h0000_1011, "status_ovf_cleared");
    tx_mode = 0;
    wait_tx_idle(3000);
    chk("tx_count_after_ovf", tx_cnt, 19);
    wb_read(2'd2, 32'h2, "status_after_drain");

    // flush discards queued bytes
    tx_mode = 1;
    tx_write(8'h91, 1'b1);
    tx_write(8'h92, 1'b1);
    tx_write(8'h93, 1'b1);
    wb_read(2'd2, 32'h0000_0310, "status_before_flush");
    wb_write(2'd3, 32'h2);
    tx_exp.delete();
    wb_read(2'd2, 32'h0000_0012, "status_after_flush");
    tx_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("tx_count_after_flush", tx_cnt, 19);

    // single receive
    send_rx(8'h5A);
    wb_read(2'd2, 32'h6, "status_rx_valid");
    wb_read(2'd1, 32'h5A, "rxdata_5a");
    wb_read(2'd2, 32'h2, "status_rx_consumed");
    wb_read(2'd1, 32'h5A, "rxdata_repeat");
    wb_read(2'd2, 32'h2, "status_repeat_no_effect");

    // overrun and interrupts
    send_rx(8'h11);
    send_rx(8'h22);
    wb_read(2'd2, 32'hE, "status_overrun");
    wb_write(2'd3, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_rx_ie", {31'h0, irq}, 32'h1);
    wb_read(2'd1, 32'h22, "rxdata_overwritten");
    repeat (2) @(posedge clk);
    #1;
    chk("irq_rx_cleared", {31'h0, irq}, 32'h0);
    wb_read(2'd2, 32'hA, "status_ovr_sticky");
    wb_write(2'd3, 32'h1);
    wb_read(2'd2, 32'h2, "status_ovr_cleared");
    wb_write(2'd3, 32'h8);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_tx_ie", {31'h0, irq}, 32'h1);
    wb_write(2'd3, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_off", {31'h0, irq}, 32'h0);

    // RXDATA read landing in the same cycle as a capture
    send_rx(8'h33);
    rx_req_word = 8'h44;
    rx_req_cnt++;
    wb_xfer(1'b0, 2'd1, 32'h0, rd);
    chk("rxdata_read_during_capture", rd, 32'h33);
    repeat (4) @(posedge clk);
    #1;
    wb_read(2'd2, 32'h6, "status_no_ovr_on_race");
    wb_read(2'd1, 32'h44, "rxdata_new_byte");

    // async reset while in SEND, R_CLR and an ack cycle
    tx_mode = 2;
    wb_write(2'd0, 32'hA1);
    wb_write(2'd0, 32'hA2);
    wb_write(2'd0, 32'hA3);
    rx_hold = 1'b1;
    rx_req_word = 8'hB7;
    rx_req_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd2;
    @(posedge clk); #1;
    chk("pre_reset_active", {29'h0, wb_ack_o, uart_valid, uart_rxne_clear}, 32'h7);
    #2;
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    chk("async_reset_drop", {29'h0, wb_ack_o, uart_valid, uart_rxne_clear}, 32'h0);
    rx_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    wb_read(2'd2, 32'h6, "status_after_reset_release");
    wb_read(2'd1, 32'hB7, "rxdata_after_reset_release");
    tx_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("tx_count_after_reset", tx_cnt, 19);
    chk("tx_no_valid_while_busy", tx_vio, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
